// File: rtl/decode_pkg.sv
// Shared x86 prefix encodings, segment override codes and accumulator states for the decode front end.
// Pure definitions: no latency, no flow control.
package decode_pkg;

  localparam logic [7:0] PFX_ES    = 8'h26;
  localparam logic [7:0] PFX_CS    = 8'h2E;
  localparam logic [7:0] PFX_SS    = 8'h36;
  localparam logic [7:0] PFX_DS    = 8'h3E;
  localparam logic [7:0] PFX_FS    = 8'h64;
  localparam logic [7:0] PFX_GS    = 8'h65;
  localparam logic [7:0] PFX_OPSZ  = 8'h66;
  localparam logic [7:0] PFX_ADSZ  = 8'h67;
  localparam logic [7:0] PFX_LOCK  = 8'hF0;
  localparam logic [7:0] PFX_REPNE = 8'hF2;
  localparam logic [7:0] PFX_REP   = 8'hF3;

  typedef enum logic [2:0] {
    SEG_ES   = 3'd0,
    SEG_CS   = 3'd1,
    SEG_SS   = 3'd2,
    SEG_DS   = 3'd3,
    SEG_FS   = 3'd4,
    SEG_GS   = 3'd5,
    SEG_NONE = 3'd7
  } seg_t;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } pfx_state_t;

endpackage

// File: rtl/prefix_byte_classify.sv
// Combinational decode of one instruction byte into prefix class flags and segment code.
// Zero latency; no flow control.
module prefix_byte_classify
  import decode_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic       is_prefix,
  output logic       is_seg,
  output logic [2:0] seg,
  output logic       is_opsz,
  output logic       is_adsz,
  output logic       is_lock,
  output logic       is_rep,
  output logic       is_repne
);

  always_comb begin
    is_seg   = 1'b1;
    seg      = SEG_NONE;
    is_opsz  = 1'b0;
    is_adsz  = 1'b0;
    is_lock  = 1'b0;
    is_rep   = 1'b0;
    is_repne = 1'b0;
    case (in_byte)
      PFX_ES:    seg = SEG_ES;
      PFX_CS:    seg = SEG_CS;
      PFX_SS:    seg = SEG_SS;
      PFX_DS:    seg = SEG_DS;
      PFX_FS:    seg = SEG_FS;
      PFX_GS:    seg = SEG_GS;
      default:   is_seg = 1'b0;
    endcase
    case (in_byte)
      PFX_OPSZ:  is_opsz  = 1'b1;
      PFX_ADSZ:  is_adsz  = 1'b1;
      PFX_LOCK:  is_lock  = 1'b1;
      PFX_REP:   is_rep   = 1'b1;
      PFX_REPNE: is_repne = 1'b1;
      default:   ;
    endcase
    is_prefix = is_seg | is_opsz | is_adsz | is_lock | is_rep | is_repne;
  end

endmodule

// File: rtl/decode_prefix_accumulator.sv
// Folds a run of x86 prefix bytes into one bundle emitted with the opcode byte; bundle valid the cycle after opcode accept.
// Byte input stalls (in_ready=0) while a bundle is held awaiting out_ready.
module decode_prefix_accumulator
  import decode_pkg::*;
#(
  parameter int MAX_PREFIX = 14,
  parameter int COUNT_W    = $clog2(MAX_PREFIX + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               default_size_32,
  input  logic               in_valid,
  input  logic [7:0]         in_byte,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_opcode,
  output logic               out_operand_size_32,
  output logic               out_address_size_32,
  output logic               out_lock,
  output logic               out_rep,
  output logic               out_repne,
  output logic [2:0]         out_segment,
  output logic [COUNT_W-1:0] out_prefix_count,
  output logic               out_fault
);

  pfx_state_t         r_state;
  pfx_state_t         w_state_nxt;
  logic [7:0]         r_opcode;
  logic               r_default;
  logic               r_op_pfx;
  logic               r_ad_pfx;
  logic               r_lock;
  logic               r_rep;
  logic               r_repne;
  logic [2:0]         r_segment;
  logic [COUNT_W-1:0] r_count;
  logic               r_fault;

  logic       w_is_prefix, w_is_seg, w_is_opsz, w_is_adsz;
  logic       w_is_lock, w_is_rep, w_is_repne;
  logic [2:0] w_seg;
  logic       w_take_pfx, w_overflow, w_take_op, w_release;

  prefix_byte_classify u_classify (
    .in_byte   (in_byte),
    .is_prefix (w_is_prefix),
    .is_seg    (w_is_seg),
    .seg       (w_seg),
    .is_opsz   (w_is_opsz),
    .is_adsz   (w_is_adsz),
    .is_lock   (w_is_lock),
    .is_rep    (w_is_rep),
    .is_repne  (w_is_repne)
  );

  always_comb begin
    w_take_pfx  = 1'b0;
    w_overflow  = 1'b0;
    w_take_op   = 1'b0;
    w_release   = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      ACCUM: begin
        if (in_valid) begin
          if (!w_is_prefix) begin
            w_take_op   = 1'b1;
            w_state_nxt = HOLD;
          end else if (r_count == COUNT_W'(MAX_PREFIX)) begin
            w_overflow  = 1'b1;
            w_state_nxt = HOLD;
          end else begin
            w_take_pfx  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_release   = 1'b1;
          w_state_nxt = ACCUM;
        end
      end
      default: w_state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || flush) r_state <= ACCUM;
    else                r_state <= w_state_nxt;
  end

  // Flush clears the latched default too, so a flushed front end looks freshly reset.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_opcode  <= 8'h00;
      r_default <= 1'b0;
      r_op_pfx  <= 1'b0;
      r_ad_pfx  <= 1'b0;
      r_lock    <= 1'b0;
      r_rep     <= 1'b0;
      r_repne   <= 1'b0;
      r_segment <= SEG_NONE;
      r_count   <= '0;
      r_fault   <= 1'b0;
    end else if (w_release) begin
      r_op_pfx  <= 1'b0;
      r_ad_pfx  <= 1'b0;
      r_lock    <= 1'b0;
      r_rep     <= 1'b0;
      r_repne   <= 1'b0;
      r_segment <= SEG_NONE;
      r_count   <= '0;
      r_fault   <= 1'b0;
    end else if (w_take_op) begin
      r_opcode  <= in_byte;
      r_default <= default_size_32;
    end else if (w_overflow) begin
      r_opcode  <= in_byte;
      r_fault   <= 1'b1;
    end else if (w_take_pfx) begin
      r_count <= r_count + 1'b1;
      if (w_is_opsz)  r_op_pfx  <= 1'b1;
      if (w_is_adsz)  r_ad_pfx  <= 1'b1;
      if (w_is_lock)  r_lock    <= 1'b1;
      if (w_is_seg)   r_segment <= w_seg;
      if (w_is_rep) begin
        r_rep   <= 1'b1;
        r_repne <= 1'b0;
      end
      if (w_is_repne) begin
        r_rep   <= 1'b0;
        r_repne <= 1'b1;
      end
    end
  end

  assign in_ready            = (r_state == ACCUM);
  assign out_valid           = (r_state == HOLD);
  assign out_opcode          = r_opcode;
  assign out_operand_size_32 = r_default ^ r_op_pfx;
  assign out_address_size_32 = r_default ^ r_ad_pfx;
  assign out_lock            = r_lock;
  assign out_rep             = r_rep;
  assign out_repne           = r_repne;
  assign out_segment         = r_segment;
  assign out_prefix_count    = r_count;
  assign out_fault           = r_fault;

endmodule

// File: tb/tb_decode_prefix_accumulator.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized traffic against a queue-based model.
module tb_decode_prefix_accumulator;

  localparam int MAX = 14;
  localparam int CW  = $clog2(MAX + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          default_size_32 = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_byte = 8'h00;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    out_opcode;
  logic          out_operand_size_32;
  logic          out_address_size_32;
  logic          out_lock;
  logic          out_rep;
  logic          out_repne;
  logic [2:0]    out_segment;
  logic [CW-1:0] out_prefix_count;
  logic          out_fault;

  decode_prefix_accumulator #(.MAX_PREFIX(MAX)) dut (
    .clock               (clock),
    .reset               (reset),
    .flush               (flush),
    .default_size_32     (default_size_32),
    .in_valid            (in_valid),
    .in_byte             (in_byte),
    .in_ready            (in_ready),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_opcode          (out_opcode),
    .out_operand_size_32 (out_operand_size_32),
    .out_address_size_32 (out_address_size_32),
    .out_lock            (out_lock),
    .out_rep             (out_rep),
    .out_repne           (out_repne),
    .out_segment         (out_segment),
    .out_prefix_count    (out_prefix_count),
    .out_fault           (out_fault)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: the accepted prefixes of the current instruction, replayed when it closes.
  logic [7:0] m_q[$];
  logic       m_hold = 1'b0;
  logic       m_lat  = 1'b0;
  logic [7:0] e_opc;
  logic       e_op32, e_ad32, e_lock, e_rep, e_repne, e_fault;
  logic [2:0] e_seg;
  int         e_cnt;
  logic       dflt = 1'b0;

  logic [7:0] pfx_list [11] = '{8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65,
                                8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3};

  function automatic logic is_pfx(input logic [7:0] b);
    foreach (pfx_list[i]) if (pfx_list[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic form_bundle(input logic [7:0] opc, input logic f);
    logic op, ad;
    op = 0; ad = 0;
    e_lock = 0; e_rep = 0; e_repne = 0; e_seg = 3'd7;
    foreach (m_q[i]) begin
      case (m_q[i])
        8'h26: e_seg = 3'd0;
        8'h2E: e_seg = 3'd1;
        8'h36: e_seg = 3'd2;
        8'h3E: e_seg = 3'd3;
        8'h64: e_seg = 3'd4;
        8'h65: e_seg = 3'd5;
        8'h66: op = 1;
        8'h67: ad = 1;
        8'hF0: e_lock = 1;
        8'hF2: begin e_repne = 1; e_rep = 0; end
        8'hF3: begin e_rep = 1; e_repne = 0; end
        default: ;
      endcase
    end
    e_opc   = opc;
    e_fault = f;
    e_cnt   = m_q.size();
    e_op32  = m_lat ^ op;
    e_ad32  = m_lat ^ ad;
  endtask

  task automatic model_step(input logic v, input logic [7:0] b, input logic rdy,
                            input logic fl, input logic rs, input logic d);
    if (rs || fl) begin
      m_hold = 0;
      m_q.delete();
      m_lat = 0;
    end else if (!m_hold) begin
      if (v) begin
        if (!is_pfx(b)) begin
          m_lat = d;
          form_bundle(b, 1'b0);
          m_hold = 1;
        end else if (m_q.size() < MAX) begin
          m_q.push_back(b);
        end else begin
          form_bundle(b, 1'b1);
          m_hold = 1;
        end
      end
    end else if (rdy) begin
      m_hold = 0;
      m_q.delete();
    end
  endtask

  task automatic model_compare();
    chk("in_ready", 32'(in_ready), 32'(!m_hold));
    chk("out_valid", 32'(out_valid), 32'(m_hold));
    if (m_hold) begin
      chk("opcode",  32'(out_opcode), 32'(e_opc));
      chk("op32",    32'(out_operand_size_32), 32'(e_op32));
      chk("ad32",    32'(out_address_size_32), 32'(e_ad32));
      chk("lock",    32'(out_lock), 32'(e_lock));
      chk("rep",     32'(out_rep), 32'(e_rep));
      chk("repne",   32'(out_repne), 32'(e_repne));
      chk("segment", 32'(out_segment), 32'(e_seg));
      chk("count",   32'(out_prefix_count), 32'(e_cnt));
      chk("fault",   32'(out_fault), 32'(e_fault));
    end else begin
      chk("acc_count", 32'(out_prefix_count), 32'(m_q.size()));
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] b, input logic rdy,
                       input logic fl, input logic rs);
    @(negedge clock);
    in_valid = v; in_byte = b; out_ready = rdy; flush = fl; reset = rs;
    default_size_32 = dflt;
    model_step(v, b, rdy, fl, rs, dflt);
    @(posedge clock);
    #1;
    model_compare();
  endtask

  task automatic send(input logic [7:0] b, input logic rdy);
    cycle(1'b1, b, rdy, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 8'h00, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] seq [];
    int bias;

    // Reset state
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_opcode", 32'(out_opcode), 32'h00);
    chk("rst_segment", 32'(out_segment), 32'd7);
    chk("rst_count", 32'(out_prefix_count), 32'd0);
    chk("rst_fault", 32'(out_fault), 32'd0);
    chk("rst_op32", 32'(out_operand_size_32), 32'd0);
    chk("rst_ad32", 32'(out_address_size_32), 32'd0);
    chk("rst_flags", 32'({out_lock, out_rep, out_repne}), 32'd0);

    // 66 2E F3 A5 with 32-bit default
    dflt = 1'b1;
    seq = '{8'h66, 8'h2E, 8'hF3, 8'hA5};
    foreach (seq[i]) send(seq[i], 1'b1);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_opcode", 32'(out_opcode), 32'hA5);
    chk("t1_op32", 32'(out_operand_size_32), 32'd0);
    chk("t1_ad32", 32'(out_address_size_32), 32'd1);
    chk("t1_seg", 32'(out_segment), 32'd1);
    chk("t1_rep", 32'({out_rep, out_repne}), 32'b10);
    chk("t1_count", 32'(out_prefix_count), 32'd3);
    chk("t1_fault", 32'(out_fault), 32'd0);
    idle(1'b1);

    // Last segment and last REP variant win
    seq = '{8'h26, 8'h64, 8'hF2, 8'hF3, 8'h90};
    foreach (seq[i]) send(seq[i], 1'b1);
    chk("t2_seg", 32'(out_segment), 32'd4);
    chk("t2_rep", 32'({out_rep, out_repne}), 32'b10);
    chk("t2_count", 32'(out_prefix_count), 32'd4);
    idle(1'b1);

    // Backpressure: held bundle stays stable, input stalled
    dflt = 1'b0;
    send(8'h0F, 1'b0);
    for (int i = 0; i < 5; i++) begin
      dflt = ~dflt;
      send(8'h66, 1'b0);
      chk("t3_hold_valid", 32'(out_valid), 32'd1);
      chk("t3_hold_inrdy", 32'(in_ready), 32'd0);
      chk("t3_hold_opc", 32'(out_opcode), 32'h0F);
      chk("t3_hold_op32", 32'(out_operand_size_32), 32'd0);
    end
    idle(1'b1);
    chk("t3_rel_inrdy", 32'(in_ready), 32'd1);
    chk("t3_rel_count", 32'(out_prefix_count), 32'd0);
    send(8'h90, 1'b0);
    chk("t3_next_valid", 32'(out_valid), 32'd1);
    idle(1'b1);

    // Prefix limit
    for (int i = 0; i < MAX + 1; i++) send(8'h66, 1'b0);
    chk("t4_fault", 32'(out_fault), 32'd1);
    chk("t4_opcode", 32'(out_opcode), 32'h66);
    chk("t4_count", 32'(out_prefix_count), 32'd14);
    idle(1'b1);
    send(8'h66, 1'b1);
    send(8'h90, 1'b1);
    chk("t4_fresh_count", 32'(out_prefix_count), 32'd1);
    chk("t4_fresh_fault", 32'(out_fault), 32'd0);
    idle(1'b1);

    // Flush mid-instruction, byte in flush cycle discarded
    send(8'h26, 1'b1);
    send(8'hF0, 1'b1);
    cycle(1'b1, 8'h90, 1'b1, 1'b1, 1'b0);
    chk("t5_flush_valid", 32'(out_valid), 32'd0);
    send(8'h90, 1'b1);
    chk("t5_count", 32'(out_prefix_count), 32'd0);
    chk("t5_seg", 32'(out_segment), 32'd7);
    chk("t5_fault", 32'(out_fault), 32'd0);
    idle(1'b1);
    // Flush in HOLD beats the handshake
    send(8'h65, 1'b1);
    send(8'h0F, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("t5_hflush_valid", 32'(out_valid), 32'd0);
    send(8'h90, 1'b1);
    chk("t5_h_count", 32'(out_prefix_count), 32'd0);
    chk("t5_h_seg", 32'(out_segment), 32'd7);
    idle(1'b1);

    // Reset mid-instruction
    send(8'hF0, 1'b1);
    cycle(1'b1, 8'h90, 1'b1, 1'b0, 1'b1);
    chk("t6_inrdy", 32'(in_ready), 32'd1);
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_lock", 32'(out_lock), 32'd0);
    send(8'h90, 1'b1);
    chk("t6_count", 32'(out_prefix_count), 32'd0);
    chk("t6_lock2", 32'(out_lock), 32'd0);
    idle(1'b1);

    // Randomized traffic, alternating light and heavy prefix density
    for (int i = 0; i < 4000; i++) begin
      logic v, rdy, fl, rs;
      logic [7:0] b;
      bias = ((i / 500) % 2 == 1) ? 97 : 40;
      v    = ($urandom_range(0, 3) != 0);
      b    = ($urandom_range(0, 99) < bias) ? pfx_list[$urandom_range(0, 10)]
                                            : 8'($urandom_range(0, 255));
      rdy  = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 99) < 1);
      rs   = ($urandom_range(0, 399) == 0);
      dflt = 1'($urandom_range(0, 1));
      cycle(v, b, rdy, fl, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_prefix_accumulator.md
# decode_prefix_accumulator

Sequential x86 prefix accumulator in the front-end decode stage. Consumes the instruction byte stream one byte per cycle and folds any run of prefix bytes into a single prefix bundle. Emits the bundle together with the first non-prefix (opcode) byte to the opcode decoder over a valid/ready handshake. Covers REP/REPNE, last-wins segment override, the effective operand and address size, and a parametrised prefix-count limit that raises a fault.

## Interface
- `MAX_PREFIX`, 14: maximum number of accepted prefix bytes per instruction; one more prefix raises a fault.
- `COUNT_W`, `$clog2(MAX_PREFIX+1)`: width of the prefix counter (derived).

- `clock`  in  1  sole clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous abort on a branch or fault; drops any partial or held instruction.
- `default_size_32`  in  1  code-segment D bit; 1 selects 32-bit default operand and address size.
- `in_valid`  in  1  `in_byte` is valid.
- `in_byte`  in  8  instruction byte.
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`.
- `out_valid`  out  1  bundle valid.
- `out_ready`  in  1  downstream accepts the bundle.
- `out_opcode`  out  8  first non-prefix byte, or the offending byte on a fault.
- `out_operand_size_32`  out  1  effective operand size.
- `out_address_size_32`  out  1  effective address size.
- `out_lock`  out  1  F0 seen.
- `out_rep`  out  1  F3 wins.
- `out_repne`  out  1  F2 wins.
- `out_segment`  out  3  override: ES=0, CS=1, SS=2, DS=3, FS=4, GS=5, NONE=7.
- `out_prefix_count`  out  `COUNT_W`  number of prefixes accepted.
- `out_fault`  out  1  prefix limit exceeded.

## Operation
- Two states.
  - ACCUM: `in_ready=1`, `out_valid=0`.
  - HOLD: `in_ready=0`, `out_valid=1`.
- Prefix bytes are 26, 2E, 36, 3E, 64, 65, 66, 67, F0, F2, F3. All other bytes are opcodes.
- An accepted prefix in ACCUM with `count < MAX_PREFIX` updates state and increments the count. State stays ACCUM.
  - 66 and 67 set sticky flags `op_pfx` and `ad_pfx`.
  - F0 sets `lock`.
  - Segment prefix overwrites `segment`, so the last one wins.
  - F3 sets `rep=1, repne=0`; F2 sets `repne=1, rep=0`, so the last one wins.
  - Repeated identical prefixes are legal and each one counts.
- An accepted opcode in ACCUM captures `out_opcode`, latches `default_size_32`, and moves to HOLD.
- An accepted prefix with `count == MAX_PREFIX` does the following:
  - captures the byte as `out_opcode`;
  - sets `out_fault=1`;
  - leaves the count and flags unmodified;
  - moves to HOLD.
- Effective sizes: `out_operand_size_32 = latched_default ^ op_pfx`, and likewise for address size with `ad_pfx`.
- HOLD with `out_ready=1`: clear all flags, set count to 0 and segment to NONE, clear fault, return to ACCUM. Outputs remain stable in HOLD until the handshake.
- Priority: `reset` > `flush` > handshake logic.
  - `flush` in any state forces the reset state in the next cycle.
  - A byte presented in the same cycle as `flush` is discarded.
  - A held bundle is dropped even if `out_ready=1` in that cycle.
- Reset values:
  - state ACCUM, `out_valid=0`, `in_ready=1`;
  - `out_opcode=8'h00`, all flag outputs 0, `out_segment=3'd7`, `out_prefix_count=0`, `out_fault=0`;
  - `out_operand_size_32` and `out_address_size_32` are 0, because the latched default resets to 0.

## Timing
- All outputs are registered, except `in_ready`, which is decoded from the state register.
- Latency: the opcode byte accepted at edge N gives `out_valid=1` after edge N.
- Throughput: one byte per cycle in ACCUM. HOLD always costs at least one cycle with no byte accepted, so an instruction with P prefixes takes at least P+2 cycles.
- `default_size_32` is sampled only on the opcode-accept edge. Changes while in HOLD have no effect.
- The counter never wraps. Saturation is handled by the fault path.

## Structure
- Package `decode_pkg` holds:
  - the prefix byte localparams (`PFX_CS` and the others);
  - `seg_t` enum (ES..GS, NONE=7);
  - `pfx_state_t` enum {ACCUM, HOLD}.
- Sub-module `prefix_byte_classify`: purely combinational. Takes a byte and outputs `is_prefix`, `is_seg`, `seg`, `is_opsz`, `is_adsz`, `is_lock`, `is_rep`, `is_repne`.
- The accumulator holds only the sequential logic.

## Test plan
- `default_size_32=1`, bytes 66,2E,F3,A5 with `out_ready=1` → one bundle: opcode A5, `operand_size_32=0`, `address_size_32=1`, segment=1, `rep=1`, `repne=0`, count=3, fault=0.
- Bytes 26,64,F2,F3,90 → segment=4 (FS), `rep=1`, `repne=0`, count=4.
- `out_ready=0` for 5 cycles after opcode 0F → `out_valid` held, outputs stable, `in_ready=0`. Release → next byte accepted 1 cycle later, count back to 0.
- `MAX_PREFIX=14`, 15 bytes of 66 → bundle with fault=1, opcode=66, count=14. A further 66 after the handshake starts a fresh instruction.
- `flush` asserted after 2 prefixes, and separately in HOLD with `out_ready=1` → no bundle emitted. The next byte 90 yields count=0, segment=7, fault=0.
- `reset` mid-instruction (after F0) → next cycle `in_ready=1`, `out_valid=0`, `out_lock=0`. A following opcode alone gives count=0.
